// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Used by bcd_digit_sub3 and bcd_to_binary_seq.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W     = 4;
  localparam int BCD_MAX_DIGIT   = 9;
  localparam int BCD_CORR_THRESH = 8;
  localparam int BCD_CORR_VAL    = 3;

  // A 4-bit BCD digit above 9 cannot come from a legal decimal source.
  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_DIGIT_W'(BCD_MAX_DIGIT));
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One reverse double-dabble correction cell: digits of 8 or more lose 3
// after the right shift, with no borrow into the neighbouring digit.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Conditional subtract-3 on a single shifted digit.
  always_comb begin
    if (d >= BCD_DIGIT_W'(BCD_CORR_THRESH)) begin
      q = d - BCD_DIGIT_W'(BCD_CORR_VAL);
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit
// per cycle). Optional invalid-digit detection via BCD_INVALID_CHECK_EN.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if ((DIGITS < 1) || (DIGITS > 4)) begin : g_bad_digits
    $error("bcd_to_binary_seq: DIGITS must be in 1..4");
  end
  if ((2 ** BIN_W) <= ((10 ** DIGITS) - 1)) begin : g_bad_width
    $error("bcd_to_binary_seq: BIN_W too narrow for 10^DIGITS-1");
  end

  state_e               state_r;
  logic [BCD_W-1:0]     bcd_reg_r;
  logic [BIN_W-1:0]     bin_reg_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 err_r;
  logic                 err_pend_r;
  logic [BIN_W-1:0]     bin_out_r;

  logic [BCD_W-1:0]     bcd_shift_s;
  logic [BCD_W-1:0]     bcd_next_s;
  logic [BIN_W-1:0]     bin_next_s;
  logic                 bad_digit_s;

  // The BCD LSB falls into the binary MSB; each digit is then corrected.
  assign bcd_shift_s = {1'b0, bcd_reg_r[BCD_W-1:1]};
  assign bin_next_s  = {bcd_reg_r[0], bin_reg_r[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .d (bcd_shift_s[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (bcd_next_s [g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_INVALID_CHECK_EN
  // Flag any digit of the incoming word above 9.
  always_comb begin
    bad_digit_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_digit_s = bad_digit_s | digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end
`else
  assign bad_digit_s = 1'b0;
`endif

  // Control FSM with datapath registers; outputs lag state by one cycle so
  // busy covers the done cycle and a start during done is dropped.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r    <= IDLE;
      bcd_reg_r  <= '0;
      bin_reg_r  <= '0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_pend_r <= 1'b0;
      bin_out_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start && !done_r) begin
            bcd_reg_r  <= bcd_in;
            bin_reg_r  <= '0;
            cnt_r      <= '0;
            err_r      <= 1'b0;
            err_pend_r <= bad_digit_s;
            busy_r     <= 1'b1;
            state_r    <= CONV;
          end else begin
            busy_r <= 1'b0;
          end
        end
        CONV: begin
          // An invalid word bypasses the shift steps entirely.
          if (err_pend_r) begin
            state_r <= DONE;
          end else begin
            bcd_reg_r <= bcd_next_s;
            bin_reg_r <= bin_next_s;
            cnt_r     <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
              state_r <= DONE;
            end else begin
              state_r <= CONV;
            end
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
          if (err_pend_r) begin
            bin_out_r <= '0;
            err_r     <= 1'b1;
          end else begin
            bin_out_r <= bin_reg_r;
            err_r     <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bin_out = bin_out_r;
  assign err     = err_r;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (DIGITS=2, BIN_W=7); the invalid
// digit section runs only when BCD_INVALID_CHECK_EN is defined.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int LAT    = BIN_W + 1;

  logic                  Clock;
  logic                  Resetn;
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  int checks;
  int errors;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Decimal value of a packed BCD word.
  function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
    int v;
    int w;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(b[i*4 +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] b;
    int r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start from IDLE at a falling edge and check the whole transaction.
  task automatic run_conv(input logic [4*DIGITS-1:0] bcd, input int exp_lat,
                          input bit exp_err, input string tag);
    int cyc;
    int exp_val;
    exp_val = exp_err ? 0 : bcd_value(bcd);
    start  = 1'b1;
    bcd_in = bcd;
    @(negedge Clock);
    start  = 1'b0;
    bcd_in = 8'($urandom);
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge Clock);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_bin_out"}, {25'd0, bin_out}, exp_val);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge Clock);
    chk({tag, "_done_drop"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "_hold"}, {24'd0, err, bin_out}, {24'd0, exp_err, 7'(exp_val)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int perm [100];
    int tmp;
    int j;
    int done_cnt;

    checks = 0;
    errors = 0;
    Resetn = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge Clock);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_bin_out", {25'd0, bin_out}, 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    run_conv(8'h42, LAT, 1'b0, "h42");
    run_conv(8'h00, LAT, 1'b0, "h00");
    run_conv(8'h99, LAT, 1'b0, "h99");
    run_conv(8'h09, LAT, 1'b0, "h09");
    run_conv(8'h10, LAT, 1'b0, "h10");

    // All 100 valid inputs in a random order with random idle gaps.
    for (int i = 0; i < 100; i++) perm[i] = i;
    for (int i = 99; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 100; i++) begin
      run_conv(to_bcd(perm[i]), LAT, 1'b0, "sweep");
      repeat ($urandom_range(2, 0)) @(negedge Clock);
    end

    // Starts while busy and during the done cycle must be dropped.
    start  = 1'b1;
    bcd_in = 8'h37;
    @(negedge Clock);
    start  = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (done === 1'b1) done_cnt++;
      if (k == 8) begin
        chk("ign_done_at_8", {31'd0, done}, 32'd1);
        chk("ign_result_37", {25'd0, bin_out}, 32'd37);
      end
      if (k == 9) chk("ign_not_accepted", {31'd0, busy}, 32'd0);
      start  = (k == 3 || k == 8);
      bcd_in = start ? 8'h55 : 8'h00;
    end
    chk("ign_single_done", done_cnt, 32'd1);
    run_conv(8'h55, LAT, 1'b0, "h55_after");

    // Asynchronous reset in the middle of a conversion.
    start  = 1'b1;
    bcd_in = 8'h63;
    @(negedge Clock);
    start  = 1'b0;
    repeat (4) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rst_outputs", {22'd0, busy, done, err, bin_out}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge Clock);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("mid_rst_no_done", done_cnt, 32'd0);
    run_conv(8'h21, LAT, 1'b0, "h21_after_rst");

`ifdef BCD_INVALID_CHECK_EN
    run_conv(8'h1A, 2, 1'b1, "inv_1A");
    repeat (3) @(negedge Clock);
    chk("inv_err_held", {31'd0, err}, 32'd1);
    run_conv(8'h12, LAT, 1'b0, "inv_then_12");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential packed-BCD to unsigned-binary converter, the reverse of the team's binary-to-BCD display path. It takes DIGITS packed BCD digits and produces their binary value using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is 8 or more. It sits between BCD sources (switch banks, BCD counters) and binary arithmetic, using a start/busy/done handshake.

Parameters:
DIGITS, 2, number of packed BCD input digits (1..4).
BIN_W, 7, width of the binary result. Must satisfy 2^BIN_W > 10^DIGITS - 1; an elaboration-time check fails otherwise.

Ports:
Clock  input  1  rising-edge clock.
Resetn  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; bcd_in sampled on the same edge.
bcd_in  input  4*DIGITS  packed BCD; digit 0 in [3:0].
busy  output  1  high from the cycle after an accepted start through the done cycle.
done  output  1  one-cycle pulse when bin_out is valid.
bin_out  output  BIN_W  result; held from done until the next accepted start.
err  output  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, Resetn=0): state=IDLE, busy=0, done=0, err=0, bin_out=0, internal shift registers=0. Reset takes effect immediately, including in the middle of a conversion; any partial result is discarded.
- States: IDLE, CONV, DONE.
- IDLE: on start=1, load bcd_reg<=bcd_in, bin_reg<=0, cnt<=0, err<=0, then go to CONV. While start=0, stay in IDLE.
- CONV, one step per cycle:
  - shift {bcd_reg,bin_reg} right by 1, with bcd_reg LSB moving into bin_reg MSB;
  - then, per digit, if the shifted digit >= 8, subtract 3 (4-bit, no borrow between digits);
  - cnt increments each step; after the BIN_W-th step go to DONE.
- DONE: bin_out<=bin_reg, done=1 for exactly this cycle, then go to IDLE.
- Latency: start accepted on edge 0 gives done high in the cycle after edge BIN_W+1. With the default BIN_W=7, done is high 8 cycles after start.
- start while busy=1 is ignored; it is not queued.
- start arriving in the same cycle that done is high is also ignored. It is accepted from the following IDLE cycle onward.
- busy=1 in CONV and DONE; otherwise 0.
- Widths: cnt is clog2(BIN_W+1) bits. All arithmetic is unsigned. When the input is valid, bcd_reg is 0 after the last step.

Optional Feature:
Macro BCD_INVALID_CHECK_EN.
- Defined:
  - on an accepted start, if any digit of bcd_in is > 9, the block skips CONV and goes straight to DONE;
  - in that DONE cycle, err=1 and bin_out=0;
  - err is held until the next accepted start or reset.
- Undefined: no digit check is made and err is tied to 0. Invalid digits are converted by the same algorithm and the result is unspecified; verification must not check it.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (IDLE, CONV, DONE);
  - BCD_DIGIT_W=4;
  - BCD_MAX_DIGIT=9;
  - BCD_CORR_THRESH=8;
  - BCD_CORR_VAL=3.
- One sub-module, bcd_digit_sub3: a combinational 4-bit block that outputs d>=8 ? d-3 : d. It is instantiated DIGITS times with a generate loop.

Test Plan:
- Reset, then start with bcd_in=8'h42: busy rises the next cycle; done pulses 8 cycles after start; bin_out=7'd42; err=0.
- Boundary values, each checked at done:
  - bcd_in=8'h00 gives bin_out=0;
  - bcd_in=8'h99 gives bin_out=7'd99;
  - bcd_in=8'h09 gives 9;
  - bcd_in=8'h10 gives 10.
  - Sweep all 100 valid inputs against a reference model.
- Start 8'h37, then pulse start with 8'h55 on cycles 3 and 8 (busy, done): result is 37, no second done. Start on cycle 9 yields 55.
- Drop Resetn low at cycle 4 of a conversion of 8'h63: all outputs go to 0 immediately. After release, no done appears until a new start. A new start with 8'h21 gives 21.
- With BCD_INVALID_CHECK_EN, start with 8'h1A: done occurs 2 cycles after start with err=1 and bin_out=0. A next start with 8'h12 clears err and gives 12.
- With DIGITS=3 and BIN_W=10, bcd_in=12'h999: bin_out=10'd999, with done 11 cycles after start.
